// File: rtl/req_gnt_pkg.sv
// Shared types and helpers for the two-requester grant responder: FSM states, latency bounds, clamp.
// Pure declarations, no timing or flow-control behaviour of its own.
package req_gnt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } state_t;

    localparam int unsigned LAT_W       = 6;
    localparam int unsigned MIN_LAT_DEF = 4;
    localparam int unsigned MAX_LAT_DEF = 32;

    function automatic logic [LAT_W-1:0] clamp_lat(
        input logic [LAT_W-1:0] lat,
        input int unsigned      min_lat,
        input int unsigned      max_lat
    );
        int unsigned l;
        l = {26'd0, lat};
        if (l < min_lat)
            return LAT_W'(min_lat);
        else if (l > max_lat)
            return LAT_W'(max_lat);
        else
            return lat;
    endfunction

endpackage

// File: rtl/req_gnt_lat_cnt.sv
// Loadable down-counter timing the request-to-grant wait; load has priority over decrement.
// Terminal-count flag is a decode of the counter register, stops at zero, no backpressure.
module req_gnt_lat_cnt
    import req_gnt_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [LAT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (load)
            cnt_q <= load_val;
        else if (dec && (cnt_q != '0))
            cnt_q <= cnt_q - LAT_W'(1);
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/req_gnt_responder.sv
// Two-requester round-robin responder: grant pulses one cycle after edge T+clamp(lat_cfg); all outputs registered.
// Requests are level-held until granted; dropping the winner aborts with err. Optional grant counter under RGR_STATS_EN.
module req_gnt_responder
    import req_gnt_pkg::*;
#(
    parameter int unsigned MIN_LAT = MIN_LAT_DEF,
    parameter int unsigned MAX_LAT = MAX_LAT_DEF,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req1,
    input  logic             req2,
    input  logic [LAT_W-1:0] lat_cfg,
    output logic             gnt1,
    output logic             gnt2,
    output logic             busy,
    output logic             err
`ifdef RGR_STATS_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt
`endif
);

    state_t state_q, state_d;
    // winner: 0 = req1, 1 = req2. prio2: next tie goes to req2 (req1 granted last).
    logic winner_q, winner_d;
    logic prio2_q, prio2_d;
    logic gnt1_d, gnt2_d, busy_d, err_d;
    logic cnt_load, cnt_dec, cnt_tc;
    logic win_req;
    logic [LAT_W-1:0] lat_eff;

    // Counter holds Leff-1 after acceptance so terminal count lands on edge T+Leff.
    assign lat_eff = clamp_lat(lat_cfg, MIN_LAT, MAX_LAT) - LAT_W'(1);

    req_gnt_lat_cnt u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (lat_eff),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    assign win_req = winner_q ? req2 : req1;

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        prio2_d  = prio2_q;
        gnt1_d   = 1'b0;
        gnt2_d   = 1'b0;
        err_d    = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req1 || req2) begin
                    winner_d = (req1 && req2) ? prio2_q : req2;
                    cnt_load = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (!win_req) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_tc) begin
                    gnt1_d  = !winner_q;
                    gnt2_d  = winner_q;
                    prio2_d = !winner_q;
                    state_d = GRANT;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            GRANT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            winner_q <= 1'b0;
            prio2_q  <= 1'b0;
            gnt1     <= 1'b0;
            gnt2     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            prio2_q  <= prio2_d;
            gnt1     <= gnt1_d;
            gnt2     <= gnt2_d;
            busy     <= busy_d;
            err      <= err_d;
        end
    end

`ifdef RGR_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            gnt_cnt <= '0;
        else if ((gnt1_d || gnt2_d) && (gnt_cnt != '1))
            gnt_cnt <= gnt_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_req_gnt_responder.sv
// Directed bench for req_gnt_responder; each test task checks {gnt1,gnt2,busy,err} cycle by cycle.
module tb_req_gnt_responder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req1 = 1'b0;
    logic       req2 = 1'b0;
    logic [5:0] lat_cfg = 6'd4;
    logic       gnt1, gnt2, busy, err;
`ifdef RGR_STATS_EN
    logic [3:0] gnt_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    req_gnt_responder #(.MIN_LAT(4), .MAX_LAT(32), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req1    (req1),
        .req2    (req2),
        .lat_cfg (lat_cfg),
        .gnt1    (gnt1),
        .gnt2    (gnt2),
        .busy    (busy),
        .err     (err)
`ifdef RGR_STATS_EN
        ,
        .gnt_cnt (gnt_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        req1 = 1'b0;
        req2 = 1'b0;
        rst  = 1'b1;
        step();
        step();
        rst  = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] obs;
        #2;
        obs = {gnt1, gnt2, busy, err};
        n_cmp++;
        if (obs !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b exp=0000", obs);
        end
        step();
        rst = 1'b0;
    endtask

    // req1 alone, L=6; lat_cfg changed mid-wait must be ignored, req1 dropped during GRANT.
    task automatic test_single;
        logic [3:0] obs, exp;
        req1    = 1'b1;
        lat_cfg = 6'd6;
        for (int k = 0; k <= 8; k++) begin
            step();
            obs = {gnt1, gnt2, busy, err};
            exp = {(k == 6), 1'b0, (k <= 6), 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL single k=%0d got=%b exp=%b", k, obs, exp);
            end
            if (k == 1) lat_cfg = 6'd1;
            if (k == 6) req1 = 1'b0;
        end
    endtask

    // Both held from reset, L=4: grants alternate req1, req2, req1, req2 every 6 cycles.
    task automatic test_round_robin;
        logic [3:0] obs, exp;
        logic       who2;
        apply_reset();
        req1    = 1'b1;
        req2    = 1'b1;
        lat_cfg = 6'd4;
        for (int r = 0; r < 4; r++) begin
            who2 = (r % 2 == 1);
            for (int k = 0; k <= 5; k++) begin
                step();
                obs = {gnt1, gnt2, busy, err};
                exp = {(k == 4) && !who2, (k == 4) && who2, (k <= 4), 1'b0};
                n_cmp++;
                if (obs !== exp) begin
                    n_bad++;
                    $display("FAIL rr r=%0d k=%0d got=%b exp=%b", r, k, obs, exp);
                end
            end
        end
        req1 = 1'b0;
        req2 = 1'b0;
    endtask

    // lat_cfg below MIN and above MAX are clamped to 4 and 32.
    task automatic test_clamp;
        logic [3:0] obs, exp;
        int         lat_v [2]  = '{4, 32};
        logic [5:0] cfg_v [2]  = '{6'd1, 6'd50};
        for (int t = 0; t < 2; t++) begin
            req2    = 1'b1;
            lat_cfg = cfg_v[t];
            for (int k = 0; k <= lat_v[t] + 1; k++) begin
                step();
                obs = {gnt1, gnt2, busy, err};
                exp = {1'b0, (k == lat_v[t]), (k <= lat_v[t]), 1'b0};
                n_cmp++;
                if (obs !== exp) begin
                    n_bad++;
                    $display("FAIL clamp cfg=%0d k=%0d got=%b exp=%b", cfg_v[t], k, obs, exp);
                end
                if (k == lat_v[t]) req2 = 1'b0;
            end
        end
    endtask

    // Grant req1, then req2 aborts mid-wait (err, no gnt), then a tie must still favour req2.
    task automatic test_abort;
        logic [3:0] obs, exp;
        apply_reset();
        req1    = 1'b1;
        lat_cfg = 6'd4;
        for (int k = 0; k <= 5; k++) begin
            step();
            if (k == 4) req1 = 1'b0;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_pre busy got=%b exp=0", busy);
        end
        req2    = 1'b1;
        lat_cfg = 6'd10;
        for (int k = 0; k <= 6; k++) begin
            step();
            obs = {gnt1, gnt2, busy, err};
            exp = {1'b0, 1'b0, (k < 4), (k == 4)};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL abort k=%0d got=%b exp=%b", k, obs, exp);
            end
            if (k == 3) req2 = 1'b0;
        end
        req1    = 1'b1;
        req2    = 1'b1;
        lat_cfg = 6'd4;
        for (int k = 0; k <= 5; k++) begin
            step();
            obs = {gnt1, gnt2, busy, err};
            exp = {1'b0, (k == 4), (k <= 4), 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL abort_tie k=%0d got=%b exp=%b", k, obs, exp);
            end
        end
        req1 = 1'b0;
        req2 = 1'b0;
    endtask

    // Asynchronous reset during WAIT: outputs clear immediately, no err, grant never appears.
    task automatic test_mid_reset;
        logic [3:0] obs;
        req1    = 1'b1;
        lat_cfg = 6'd10;
        for (int k = 0; k <= 3; k++) step();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_pre busy got=%b exp=1", busy);
        end
        #2;
        rst  = 1'b1;
        req1 = 1'b0;
        #1;
        obs = {gnt1, gnt2, busy, err};
        n_cmp++;
        if (obs !== 4'b0000) begin
            n_bad++;
            $display("FAIL midrst_async got=%b exp=0000", obs);
        end
        step();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            obs = {gnt1, gnt2, busy, err};
            n_cmp++;
            if (obs !== 4'b0000) begin
                n_bad++;
                $display("FAIL midrst_after k=%0d got=%b exp=0000", k, obs);
            end
        end
`ifdef RGR_STATS_EN
        n_cmp++;
        if (gnt_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL midrst_cnt got=%0d exp=0", gnt_cnt);
        end
`endif
    endtask

`ifdef RGR_STATS_EN
    // 4-bit counter: 5 grants read 5, 20 grants saturate at 15, one more grant keeps 15.
    task automatic test_stats;
        apply_reset();
        req1    = 1'b1;
        lat_cfg = 6'd4;
        for (int g = 1; g <= 21; g++) begin
            for (int k = 0; k <= 5; k++) step();
            if (g == 5 || g == 20 || g == 21) begin
                n_cmp++;
                if (gnt_cnt !== ((g == 5) ? 4'd5 : 4'd15)) begin
                    n_bad++;
                    $display("FAIL stats g=%0d got=%0d exp=%0d", g, gnt_cnt, (g == 5) ? 5 : 15);
                end
            end
        end
        req1 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_clamp();
        test_abort();
        test_mid_reset();
`ifdef RGR_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/req_gnt_responder.md
REQ_GNT_RESPONDER -- requirements
Module: req_gnt_responder

Interface
REQ-001 Parameter MIN_LAT, default 4, shortest request-to-grant latency in cycles.
REQ-002 Parameter MAX_LAT, default 32, longest request-to-grant latency in cycles.
REQ-003 Parameter CNT_W, default 16, width of grant statistics counter.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req1  input  1  requester 1 request; level, held until gnt1.
REQ-007 req2  input  1  requester 2 request; level, held until gnt2.
REQ-008 lat_cfg  input  6  requested latency L, sampled at request acceptance.
REQ-009 gnt1  output  1  single-cycle grant to requester 1.
REQ-010 gnt2  output  1  single-cycle grant to requester 2.
REQ-011 busy  output  1  high in WAIT or GRANT.
REQ-012 err  output  1  one-cycle pulse: winner dropped req before grant.
REQ-013 gnt_cnt  output  CNT_W  total grants issued; present only with RGR_STATS_EN.

Function
REQ-014 FSM states IDLE, WAIT, GRANT; reset state IDLE.
REQ-015 IDLE: on edge T with any req sampled high -> accept, select winner, load latency, go WAIT.
REQ-016 Arbitration: single req wins; both high -> requester not granted last wins; pointer after reset favours req1.
REQ-017 Effective latency Leff = clamp(lat_cfg, MIN_LAT, MAX_LAT); lat_cfg sampled only at edge T, later changes ignored.
REQ-018 Winner's gnt high for exactly the cycle following edge T+Leff (state GRANT); never high two consecutive cycles.
REQ-019 GRANT -> IDLE unconditionally on next edge; req sampled in GRANT ignored; earliest next acceptance is edge T+Leff+2.
REQ-020 Round-robin pointer updates only when a grant issues, never on abort.
REQ-021 WAIT: if winner's req sampled low before edge T+Leff -> IDLE, err high one cycle, no gnt, pointer unchanged.
REQ-022 Loser's req ignored during WAIT/GRANT; no error for loser dropping.
REQ-023 gnt1 and gnt2 never high together; gntX never high while reqX was low at prior edge.
REQ-024 All outputs registered; no combinational path input -> output.

Reset
REQ-025 rst asserted: asynchronously state IDLE, gnt1=gnt2=0, busy=0, err=0, pointer favours req1, latency counter 0, gnt_cnt=0.
REQ-026 rst asserted mid-WAIT or mid-GRANT: pending grant discarded, no err pulse.
REQ-027 First acceptance possible at first rising edge after rst deasserts.

Configuration
REQ-028 Macro RGR_STATS_EN defined: gnt_cnt port present, increments on each grant, saturates at all-ones, cleared only by rst.
REQ-029 RGR_STATS_EN undefined: gnt_cnt port and counter absent; all other behaviour identical.

Structure
REQ-030 Package req_gnt_pkg: state enum, MIN_LAT/MAX_LAT default constants, clamp function for lat_cfg.
REQ-031 Sub-module req_gnt_lat_cnt: loadable 6-bit down-counter with terminal-count flag; instantiated once.
REQ-032 Target size 120-400 lines RTL total.

Verification
REQ-033 req1 high at edge 10, lat_cfg=6 -> gnt1 high only in cycle after edge 16; busy edges 10-17; req2 quiet, gnt2 stays 0.
REQ-034 req1, req2 both high at edge 5, lat_cfg=4, both held -> gnt1 after edge 9, gnt2 after edge 15 (accept edge 11), alternation continues.
REQ-035 lat_cfg=1 -> grant after 4 cycles; lat_cfg=50 -> grant after 32 cycles.
REQ-036 req2 accepted edge 20, lat_cfg=10, req2 dropped at edge 24 -> err pulse after edge 24, no gnt2, next dual contention grants req2.
REQ-037 rst pulsed at edge 25 during WAIT -> gnt never issued, outputs 0 immediately, err 0, gnt_cnt=0.
REQ-038 RGR_STATS_EN with CNT_W=4, 20 grants -> gnt_cnt reads 15 and holds.
